// File: rtl/app_ini_loader_if.sv
// APP input port bundle between the initial-message loader and the LDPC decoder.
// The master side (loader) drives the frame strobes, the segment index and the bank
// read addresses. The slave side (decoder) returns its ready and done handshakes.
interface app_ini_loader_if #(
    parameter int NUM_BANKS   = 8,
    parameter int BANK_ADDR_W = 2,
    parameter int NUM_SEGS    = 4
);
    localparam int SUB_W = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;

    logic                             buf_valid;
    logic                             buf_start;
    logic                             buf_last;
    logic [SUB_W-1:0]                 sub_x;
    logic [NUM_BANKS*BANK_ADDR_W-1:0] bank_addr;
    logic                             dec_ready;
    logic                             dec_done;

    modport master (
        output buf_valid, buf_start, buf_last, sub_x, bank_addr,
        input  dec_ready, dec_done
    );

    modport slave (
        input  buf_valid, buf_start, buf_last, sub_x, bank_addr,
        output dec_ready, dec_done
    );
endinterface

// File: rtl/app_ini_loader.sv
// app_ini_loader: streams initial APP (channel LLR) frames from NUM_BANKS input banks
// into the LDPC decoder. A frame has NUM_SEGS-1 short segments followed by one long
// segment. Bank read addresses step ADDR_LEAD cycles before each segment end so that
// ROM read latency is hidden. A job runs cfg_blk_num frames, each gated by dec_ready.
// The job finishes once the same number of dec_done pulses has been seen.
// Optional build macro APP_LOADER_SKEW_EN: bank k receives bank 0's address delayed
// by k cycles, which staggers the bank reads.
module app_ini_loader #(
    parameter int NUM_BANKS   = 8,
    parameter int BANK_ADDR_W = 2,
    parameter int NUM_SEGS    = 4,
    parameter int SEG_W       = 8,
    parameter int ADDR_LEAD   = 3,
    parameter int BLK_W       = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    app_ini_loader_if.master     app,
    input  logic                 start,
    input  logic [SEG_W-1:0]     cfg_short_len,
    input  logic [SEG_W-1:0]     cfg_long_len,
    input  logic [BLK_W-1:0]     cfg_blk_num,
    output logic [BLK_W-1:0]     blk_sent,
    output logic                 busy,
    output logic                 all_done
);
    localparam int SUB_W = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
    localparam logic [SUB_W-1:0] LAST_SEG = SUB_W'(NUM_SEGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        FILL1,
        FILL2,
        STREAM,
        WAITD,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SEG_W-1:0]       short_q;
    logic [SEG_W-1:0]       long_q;
    logic [BLK_W-1:0]       blk_num_q;
    logic [SEG_W-1:0]       seg_cnt;
    logic [SUB_W-1:0]       sub_q;
    logic [BANK_ADDR_W-1:0] addr0;
    logic [BLK_W-1:0]       blk_sent_q;
    logic [BLK_W-1:0]       done_cnt;
    logic [SEG_W-1:0]       cur_len;
    logic                   start_acc;
    logic                   last_seg;
    logic                   seg_end;
    logic                   frame_end;
    logic                   addr_step;

    // A start is honoured only while no job is in flight.
    assign start_acc = start && ((state == IDLE) || (state == DONE));
    assign last_seg  = (sub_q == LAST_SEG);
    assign cur_len   = last_seg ? long_q : short_q;
    assign seg_end   = (state == STREAM) && (seg_cnt == cur_len - SEG_W'(1));
    assign frame_end = seg_end && last_seg;
    assign addr_step = (state == STREAM) && (seg_cnt == cur_len - SEG_W'(ADDR_LEAD + 1));

    assign blk_sent  = blk_sent_q;
    assign app.sub_x = sub_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. The frame count includes the frame that is ending now.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = ARM;
            ARM:        if (app.dec_ready) state_nxt = FILL1;
            FILL1:      state_nxt = FILL2;
            FILL2:      state_nxt = STREAM;
            STREAM: begin
                if (frame_end) begin
                    if ((blk_sent_q + BLK_W'(1)) < blk_num_q) state_nxt = ARM;
                    else                                       state_nxt = WAITD;
                end
            end
            WAITD:      if (done_cnt == blk_num_q) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Frame strobes and job status are decoded from the state and segment position.
    always_comb begin
        app.buf_valid = (state == STREAM);
        app.buf_start = (state == STREAM) && (sub_q == '0) && (seg_cnt == '0);
        app.buf_last  = frame_end;
        busy          = (state != IDLE) && (state != DONE);
        all_done      = (state == DONE);
    end

    // Job configuration is latched on an accepted start and held for the whole job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            short_q   <= '0;
            long_q    <= '0;
            blk_num_q <= '0;
        end else if (start_acc) begin
            short_q   <= cfg_short_len;
            long_q    <= cfg_long_len;
            blk_num_q <= cfg_blk_num;
        end
    end

    // Segment cycle counter and segment index. Both are parked at zero outside STREAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_cnt <= '0;
            sub_q   <= '0;
        end else if (state != STREAM) begin
            seg_cnt <= '0;
            sub_q   <= '0;
        end else if (seg_end) begin
            seg_cnt <= '0;
            sub_q   <= last_seg ? '0 : sub_q + 1'b1;
        end else begin
            seg_cnt <= seg_cnt + 1'b1;
        end
    end

    // Bank 0 read address: steps early in every segment and clears between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             addr0 <= '0;
        else if ((state != STREAM) || frame_end) addr0 <= '0;
        else if (addr_step)                      addr0 <= addr0 + 1'b1;
    end

    // Frames issued in this job. The count advances on each frame's last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         blk_sent_q <= '0;
        else if (start_acc) blk_sent_q <= '0;
        else if (frame_end) blk_sent_q <= blk_sent_q + 1'b1;
    end

    // Decoder completions counted in any active state, saturating at the job size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (start_acc) begin
            done_cnt <= '0;
        end else if ((state != IDLE) && app.dec_done && (done_cnt != blk_num_q)) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end

`ifdef APP_LOADER_SKEW_EN
    logic [BANK_ADDR_W-1:0] skew_q [1:NUM_BANKS-1];

    // Delay line: stage k holds bank 0's address from k cycles earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < NUM_BANKS; k++) skew_q[k] <= '0;
        end else begin
            skew_q[1] <= addr0;
            for (int k = 2; k < NUM_BANKS; k++) skew_q[k] <= skew_q[k-1];
        end
    end

    // Bank 0 uses the live address. The other banks use their own delay stage.
    always_comb begin
        app.bank_addr = '0;
        app.bank_addr[0 +: BANK_ADDR_W] = addr0;
        for (int k = 1; k < NUM_BANKS; k++) begin
            app.bank_addr[k*BANK_ADDR_W +: BANK_ADDR_W] = skew_q[k];
        end
    end
`else
    // Every bank reads the same address in lockstep.
    always_comb begin
        app.bank_addr = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            app.bank_addr[k*BANK_ADDR_W +: BANK_ADDR_W] = addr0;
        end
    end
`endif

endmodule

// File: tb/tb_app_ini_loader.sv
// Directed testbench for app_ini_loader. It covers the reset state, a single default
// frame with an ignored start, a three-frame job with ready gating and a coincident
// done pulse, and a mid-frame reset followed by a clean restart.
// Expected addresses are tracked per cycle, so the same bench serves both builds,
// with and without APP_LOADER_SKEW_EN.
module tb_app_ini_loader;
    localparam int NUM_BANKS   = 8;
    localparam int BANK_ADDR_W = 2;
    localparam int NUM_SEGS    = 4;
    localparam int SEG_W       = 8;
    localparam int ADDR_LEAD   = 3;
    localparam int BLK_W       = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [SEG_W-1:0] cfg_short_len = '0;
    logic [SEG_W-1:0] cfg_long_len = '0;
    logic [BLK_W-1:0] cfg_blk_num = '0;
    logic [BLK_W-1:0] blk_sent;
    logic             busy;
    logic             all_done;

    int errCount = 0;
    int checkCount = 0;

    // Expected bank-0 address history: hist[k] is the value from k cycles ago.
    logic [1:0] hist [NUM_BANKS];

    app_ini_loader_if #(
        .NUM_BANKS(NUM_BANKS), .BANK_ADDR_W(BANK_ADDR_W), .NUM_SEGS(NUM_SEGS)
    ) app_if ();

    app_ini_loader #(
        .NUM_BANKS(NUM_BANKS), .BANK_ADDR_W(BANK_ADDR_W), .NUM_SEGS(NUM_SEGS),
        .SEG_W(SEG_W), .ADDR_LEAD(ADDR_LEAD), .BLK_W(BLK_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .app           (app_if),
        .start         (start),
        .cfg_short_len (cfg_short_len),
        .cfg_long_len  (cfg_long_len),
        .cfg_blk_num   (cfg_blk_num),
        .blk_sent      (blk_sent),
        .busy          (busy),
        .all_done      (all_done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = NUM_BANKS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = 2'd0;
    endtask

    task automatic clearHist();
        for (int k = 0; k < NUM_BANKS; k++) hist[k] = 2'd0;
    endtask

    // Segment index and bank-0 address expected on frame cycle c for a given configuration.
    function automatic void expSeg(input int c, input int s, input int l,
                                   output logic [1:0] sub, output logic [1:0] a0);
        int off;
        int seg;
        int len;
        off = c;
        seg = 0;
        while ((seg < NUM_SEGS - 1) && (off >= s)) begin
            off -= s;
            seg++;
        end
        len = (seg == NUM_SEGS - 1) ? l : s;
        sub = 2'(seg);
        a0  = 2'(seg + ((off > len - 1 - ADDR_LEAD) ? 1 : 0));
    endfunction

    task automatic checkCycle(input string tag, input logic eBusy, input logic eValid,
                              input logic eStart, input logic eLast,
                              input logic [1:0] eSub, input logic [1:0] eA0);
        logic [15:0] eBank;
        logic [63:0] got;
        logic [63:0] exp;
        hist[0] = eA0;
        for (int k = 0; k < NUM_BANKS; k++) begin
`ifdef APP_LOADER_SKEW_EN
            eBank[k*2 +: 2] = hist[k];
`else
            eBank[k*2 +: 2] = hist[0];
`endif
        end
        got = 64'({busy, all_done, app_if.buf_valid, app_if.buf_start, app_if.buf_last,
                   app_if.sub_x, app_if.bank_addr});
        exp = 64'({eBusy, 1'b0, eValid, eStart, eLast, eSub, eBank});
        checkOutput(tag, got, exp);
    endtask

    task automatic checkReset(input string tag);
        checkOutput(tag, 64'({busy, all_done, app_if.buf_valid, app_if.buf_start,
                              app_if.buf_last, app_if.sub_x, app_if.bank_addr, blk_sent}),
                    64'd0);
    endtask

    // Pulses start with the given configuration, then scrambles the cfg inputs.
    task automatic applyStimulus(input int s, input int l, input int n);
        cfg_short_len = SEG_W'(s);
        cfg_long_len  = SEG_W'(l);
        cfg_blk_num   = BLK_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_short_len = SEG_W'(9);
        cfg_long_len  = SEG_W'(40);
        cfg_blk_num   = BLK_W'(7);
    endtask

    // Waits in ARM with ready low, raises ready, and checks the FILL cycles.
    task automatic launch(input string tag, input int waitCycles, input logic holdReady);
        for (int i = 0; i < waitCycles; i++) begin
            checkCycle($sformatf("%s arm wait%0d", tag, i), 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
            tick();
        end
        app_if.dec_ready = 1'b1;
        checkCycle($sformatf("%s arm", tag), 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        tick();
        if (!holdReady) app_if.dec_ready = 1'b0;
        checkCycle($sformatf("%s fill1", tag), 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        tick();
        checkCycle($sformatf("%s fill2", tag), 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        tick();
    endtask

    // Checks nCycles frame cycles, optionally poking start or dec_ready on chosen cycles.
    task automatic frameRun(input string tag, input int s, input int l, input int nCycles,
                            input int startAt, input int doneAt);
        int len;
        logic [1:0] sub;
        logic [1:0] a0;
        len = (NUM_SEGS - 1) * s + l;
        for (int c = 0; c < nCycles; c++) begin
            expSeg(c, s, l, sub, a0);
            checkCycle($sformatf("%s c%0d", tag, c), 1'b1, 1'b1, c == 0, c == len - 1, sub, a0);
            if (c == startAt) start = 1'b1;
            if (c == doneAt)  app_if.dec_done = 1'b1;
            tick();
            start = 1'b0;
            app_if.dec_done = 1'b0;
        end
    endtask

    // Pulses dec_done in WAITD and checks that all_done follows one edge later.
    task automatic finishJob(input string tag);
        app_if.dec_done = 1'b1;
        tick();
        app_if.dec_done = 1'b0;
        checkOutput({tag, " all_done lag"}, 64'({busy, all_done}), 64'(2'b10));
        tick();
        checkOutput({tag, " all_done"}, 64'({busy, all_done}), 64'(2'b01));
    endtask

    initial begin
        clearHist();
        app_if.dec_ready = 1'b0;
        app_if.dec_done  = 1'b0;

        tick();
        tick();
        checkReset("reset");
        rst_n = 1'b1;
        tick();
        checkReset("idle");

        // Default 16/16/16/128 frame with one block, ready held high, start poked at cycle 50.
        applyStimulus(16, 128, 1);
        launch("t1", 0, 1'b1);
        frameRun("t1", 16, 128, 176, 50, -1);
        checkCycle("t1 waitd", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        checkOutput("t1 blk_sent", 64'(blk_sent), 64'd1);
        tick();
        tick();
        checkCycle("t1 waitd hold", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        finishJob("t1");
        tick();
        tick();
        checkOutput("t1 all_done held", 64'({busy, all_done}), 64'(2'b01));

        // Three 6/6/6/10 frames, ready low between frames, done pulses at frame 2 and last cycle.
        app_if.dec_ready = 1'b0;
        applyStimulus(6, 10, 3);
        checkOutput("t2 blk_sent clr", 64'(blk_sent), 64'd0);
        for (int f = 1; f <= 3; f++) begin
            launch($sformatf("t2 f%0d", f), 2, 1'b0);
            frameRun($sformatf("t2 f%0d", f), 6, 10, 28, -1, (f == 2) ? 5 : ((f == 3) ? 27 : -1));
            checkOutput($sformatf("t2 f%0d blk_sent", f), 64'(blk_sent), 64'(f));
        end
        checkCycle("t2 waitd", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        tick();
        tick();
        checkCycle("t2 waitd hold", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        finishJob("t2");

        // Reset at frame cycle 100, then a clean full frame.
        applyStimulus(16, 128, 1);
        launch("t3", 0, 1'b1);
        frameRun("t3", 16, 128, 100, -1, -1);
        rst_n = 1'b0;
        #1;
        checkReset("t3 async reset");
        clearHist();
        tick();
        rst_n = 1'b1;
        tick();
        checkReset("t3 after reset");
        applyStimulus(16, 128, 1);
        launch("t3r", 0, 1'b1);
        frameRun("t3r", 16, 128, 176, -1, -1);
        checkOutput("t3r blk_sent", 64'(blk_sent), 64'd1);
        finishJob("t3r");

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule

// File: doc/app_ini_loader.md
# app_ini_loader

Synthesizable input sequencer that streams initial APP (channel LLR) messages from NUM_BANKS single-port input ROM/RAM banks into the LDPC decoder's APP input port. It replaces bench-side sequencing of buffer_valid, buffer_start, buffer_last, sub-block index and per-bank read addresses. It handles a configurable per-frame segment structure, a ready-gated multi-codeblock loop, and end-of-job detection from decoder completions. It sits between the input banks and the decoder's buffer_* / APPmsg_ini_sub_x inputs.

## Interface
- NUM_BANKS, 8, number of input banks driven with read addresses
- BANK_ADDR_W, 2, per-bank address width; addresses wrap modulo 2^BANK_ADDR_W
- NUM_SEGS, 4, segments per frame; segments 0..NUM_SEGS-2 are short, the last segment is long
- SEG_W, 8, width of segment/frame cycle counters
- ADDR_LEAD, 3, cycles before segment end at which bank addresses step (covers ROM read latency)
- BLK_W, 3, width of codeblock counters
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle job start pulse; sampled only in IDLE or DONE
- cfg_short_len  in  SEG_W  cycles per short segment (e.g. 16)
- cfg_long_len  in  SEG_W  cycles in last segment (e.g. 128)
- cfg_blk_num  in  BLK_W  codeblocks per job, 1..2^BLK_W-1
- dec_ready  in  1  decoder can accept a frame (decoder buffer_ready)
- dec_done  in  1  one-cycle pulse per decoded codeblock (decoder decode_valid)
- buf_valid  out  1  frame data valid
- buf_start  out  1  first cycle of frame
- buf_last  out  1  last cycle of frame
- sub_x  out  clog2(NUM_SEGS)  current segment index
- bank_addr  out  NUM_BANKS*BANK_ADDR_W  read address per bank, bank k at bits [k*BANK_ADDR_W +: BANK_ADDR_W]
- blk_sent  out  BLK_W  frames issued in current job
- busy  out  1  state not IDLE/DONE
- all_done  out  1  job complete, held high

## Operation
- cfg_* captured on accepted start and held for the job. Legal range: cfg_short_len ≥ ADDR_LEAD+2, cfg_long_len ≥ ADDR_LEAD+2. Values outside this range are unsupported.
- States and transitions:
  - IDLE/DONE → ARM on start. start also clears blk_sent, the done counter and all_done.
  - ARM → FILL1 when dec_ready is sampled high. FILL1 → FILL2 → STREAM unconditionally.
  - STREAM runs for frame_len = (NUM_SEGS-1)*short + long cycles.
  - STREAM → ARM at frame end when blk_sent < cfg_blk_num; otherwise → WAITD.
  - WAITD → DONE when done_cnt == cfg_blk_num.
- start received in any other state is ignored.
- STREAM behaviour:
  - buf_valid is 1 every cycle.
  - buf_start is 1 on the first cycle only.
  - buf_last is 1 on the final cycle only.
  - sub_x increments at each segment end and returns to 0 at frame end.
  - blk_sent increments on the buf_last cycle.
- Address stepping: within a segment of length L, bank addresses step by 1 on the cycle where seg_cnt == L-1-ADDR_LEAD. This applies to the long segment too. Addresses reset to 0 whenever buf_valid is 0.
- done_cnt counts dec_done pulses in all non-IDLE states and saturates at cfg_blk_num.
- When dec_done and a frame end occur in the same cycle, both counters update.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset mid-frame forces the reset values immediately (asynchronous). No partial-frame recovery.
- Frame launch: dec_ready sampled high at edge E (in ARM) → buf_valid and buf_start are 1 after edge E+2.
- dec_ready is ignored outside ARM, so deasserting it mid-frame does not stall the frame.
- Back-to-back frames: at least 3 idle cycles (ARM, FILL1, FILL2) separate consecutive frames.
- all_done rises one edge after the edge on which the final dec_done is counted.
- Default config (16/16/16/128):
  - frame_len is 176.
  - buf_last falls on frame cycle 175.
  - Address steps occur at frame cycles 12, 28, 44 and 172.

## Configuration
- APP_LOADER_SKEW_EN defined: bank k's address is bank 0's address delayed by k cycles, using a per-bank shift register. This staggers bank reads.
- APP_LOADER_SKEW_EN undefined: all banks carry an identical address and no skew registers exist.

## Test plan
- Default config, cfg_blk_num=1, dec_ready held 1, start pulse:
  - buf_valid is high for exactly 176 cycles, with buf_start on the first and buf_last on the last.
  - sub_x sequence is 0×16, 1×16, 2×16, 3×128.
  - bank_addr reaches 1, 2, 3, 0 (wrap) at frame cycles 13, 29, 45, 173.
- cfg_blk_num=3, dec_ready toggled low between frames:
  - each frame waits in ARM and launches exactly 3 edges after dec_ready returns high.
  - blk_sent reads 1, 2, 3.
- In WAITD, dec_done pulses 3 times, with one coinciding with the last buf_last: all_done rises after the 3rd pulse; busy falls.
- rst_n asserted at frame cycle 100: all outputs are 0 immediately. A new start then gives a clean full frame.
- start pulsed during STREAM: ignored, with no change to the frame or counters.
- APP_LOADER_SKEW_EN defined: bank 7's address steps exactly 7 cycles after bank 0's. With the macro undefined, all banks match bank 0.
